tdc_multi: RTL and testbench

Multi-channel time-to-digital converter, the parametrised successor of the single-channel pulse-delay meter. A shared start edge on `sent_signal` arms CHANNELS independent stop inputs. Each channel's delay is measured in clock periods, with a per-channel timeout and optional multi-shot averaging. Results stream out one channel at a time over a valid/ready handshake, toward the BCD/7-segment display path or a host interface.

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tdc_channel.sv | 95 +++++++++
 rtl/tdc_multi.sv | 185 ++++++++++++++++++
 tb/tb_tdc_multi.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the multi-channel time-to-digital converter.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Width of the channel index; never less than one bit.
  function automatic int unsigned chan_w(input int unsigned channels);
    return (channels > 32'd1) ? $clog2(channels) : 32'd1;
  endfunction

endpackage

// File: rtl/tdc_channel.sv
// One TDC stop channel: synchroniser, edge detect, pending bit and shot result.
// With TDC_AVG_EN defined, shots are summed into an accumulator with a sticky timeout flag.
module tdc_channel #(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
`ifdef TDC_AVG_EN
  , parameter int unsigned AVG_LOG2     = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stop,
  input  logic             arm,
  input  logic             count_en,
  input  logic             tmo_hit,
  input  logic [CNT_W-1:0] cnt,
`ifdef TDC_AVG_EN
  input  logic             clr_acc,
`endif
  output logic             pending,
  output logic [CNT_W-1:0] delay_c,
  output logic             timeout_c
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  logic [2:0]       sync;
  logic             stop_edge;
  logic             take_stop;
  logic             take_tmo;
  logic             take;
  logic [CNT_W-1:0] shot_val;

  // sync[1:0] is the synchroniser, sync[2] the previous value for edge detect
  assign stop_edge = sync[1] & ~sync[2];
  assign take_stop = count_en & pending & stop_edge;
  assign take_tmo  = count_en & pending & ~stop_edge & tmo_hit;
  assign take      = take_stop | take_tmo;
  assign shot_val  = take_stop ? cnt : TMO;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= '0;
      pending <= 1'b0;
    end else begin
      sync <= {sync[1:0], stop};
      if (arm) begin
        pending <= ~stop_edge;
      end else if (take) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef TDC_AVG_EN
  localparam int unsigned ACC_W = CNT_W + AVG_LOG2;

  logic [ACC_W-1:0] acc;
  logic             sticky;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_acc) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (take) begin
      acc    <= acc + ACC_W'(shot_val);
      sticky <= sticky | take_tmo;
    end
  end

  assign delay_c   = CNT_W'(acc >> AVG_LOG2);
  assign timeout_c = sticky;
`else
  logic [CNT_W-1:0] cap;
  logic             tmo;

  // A stop coinciding with the start edge is recorded as zero delay
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap <= '0;
      tmo <= 1'b0;
    end else if (arm) begin
      cap <= '0;
      tmo <= 1'b0;
    end else if (take) begin
      cap <= shot_val;
      tmo <= take_tmo;
    end
  end

  assign delay_c   = cap;
  assign timeout_c = tmo;
`endif

endmodule

// File: rtl/tdc_multi.sv
// Multi-channel TDC: shared start arms CHANNELS stop inputs, results stream out over valid/ready.
// Optional multi-shot averaging is enabled by defining TDC_AVG_EN.
module tdc_multi
  import tdc_pkg::*;
#(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned AVG_LOG2       = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sent_signal,
  input  logic [CHANNELS-1:0]         recieved_signal,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [chan_w(CHANNELS)-1:0] result_chan,
  output logic [CNT_W-1:0]            result_delay,
  output logic                        result_timeout,
  output logic                        busy
);

  localparam int unsigned       CHAN_W    = chan_w(CHANNELS);
  localparam logic [CNT_W-1:0]  TMO       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

  if (CHANNELS < 1 || CHANNELS > 16 || CNT_W < 2 || AVG_LOG2 > 16 || TIMEOUT_CYCLES < 1 ||
      64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_params
    $error("tdc_multi: illegal parameter combination");
  end

  state_t            state;
  state_t            state_nx;
  logic [2:0]        start_sync;
  logic              start_edge;
  logic [CNT_W-1:0]  cnt;
  logic              tmo_hit;
  logic              arm;
  logic              count_en;
  logic              all_done;
  logic              final_shot;
  logic              hs;
  logic              last_hs;
  logic [CHAN_W-1:0] chan_inc;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] chan_tmo;
  logic [CNT_W-1:0]  chan_delay [CHANNELS];
  logic              valid_nx;
  logic [CHAN_W-1:0] chan_nx;
  logic [CNT_W-1:0]  delay_nx;
  logic              tmo_nx;
  logic              busy_nx;

  // Start path uses the same 3-flop chain as the stop paths so delays are unbiased
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_sync <= '0;
    end else begin
      start_sync <= {start_sync[1:0], sent_signal};
    end
  end

  assign start_edge = start_sync[1] & ~start_sync[2];
  assign arm        = (state == IDLE) && start_edge;
  assign count_en   = (state == COUNT);
  assign tmo_hit    = (cnt == TMO);
  assign all_done   = ~|pending;
  assign hs         = result_valid & result_ready;
  assign last_hs    = (state == OUTPUT) && hs && (result_chan == LAST_CHAN);
  assign chan_inc   = result_chan + CHAN_W'(1);

  // Delay counter saturates at the timeout value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (arm) begin
      cnt <= CNT_W'(1);
    end else if (count_en && !tmo_hit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef TDC_AVG_EN
  localparam int unsigned       SHOT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SHOT_W-1:0] SHOT_LAST = SHOT_W'((64'd1 << AVG_LOG2) - 64'd1);

  logic              clr_acc;
  logic [SHOT_W-1:0] shot;

  assign clr_acc    = last_hs;
  assign final_shot = (shot == SHOT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr_acc) begin
      shot <= '0;
    end else if (count_en && all_done && !final_shot) begin
      shot <= shot + SHOT_W'(1);
    end
  end
`else
  assign final_shot = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    tdc_channel #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`ifdef TDC_AVG_EN
      , .AVG_LOG2     (AVG_LOG2)
`endif
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .stop      (recieved_signal[i]),
      .arm       (arm),
      .count_en  (count_en),
      .tmo_hit   (tmo_hit),
      .cnt       (cnt),
`ifdef TDC_AVG_EN
      .clr_acc   (clr_acc),
`endif
      .pending   (pending[i]),
      .delay_c   (chan_delay[i]),
      .timeout_c (chan_tmo[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_edge) state_nx = COUNT;
      COUNT:   if (all_done) state_nx = final_shot ? OUTPUT : IDLE;
      OUTPUT:  if (last_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered result port; held while stalled
  always_comb begin
    valid_nx = result_valid;
    chan_nx  = result_chan;
    delay_nx = result_delay;
    tmo_nx   = result_timeout;
    busy_nx  = (state_nx != IDLE);
    if (count_en && all_done && final_shot) begin
      valid_nx = 1'b1;
      chan_nx  = '0;
      delay_nx = chan_delay[0];
      tmo_nx   = chan_tmo[0];
    end else if ((state == OUTPUT) && hs) begin
      if (last_hs) begin
        valid_nx = 1'b0;
      end else begin
        chan_nx  = chan_inc;
        delay_nx = chan_delay[chan_inc];
        tmo_nx   = chan_tmo[chan_inc];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_valid   <= 1'b0;
      result_chan    <= '0;
      result_delay   <= '0;
      result_timeout <= 1'b0;
      busy           <= 1'b0;
    end else begin
      result_valid   <= valid_nx;
      result_chan    <= chan_nx;
      result_delay   <= delay_nx;
      result_timeout <= tmo_nx;
      busy           <= busy_nx;
    end
  end

endmodule

// File: tb/tb_tdc_multi.sv
// Bench for tdc_multi: directed and randomized shots scored against a per-channel delay model.
`timescale 1ns/1ps
module tb_tdc_multi;

  localparam int CH   = 4;
  localparam int CW   = 16;
  localparam int TMO  = 50;
  localparam int AVG  = 2;
`ifdef TDC_AVG_EN
  localparam int SHOTS = 1 << AVG;
`else
  localparam int SHOTS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sent_signal;
  logic [CH-1:0] recieved_signal;
  logic          result_valid;
  logic          result_ready;
  logic [1:0]    result_chan;
  logic [CW-1:0] result_delay;
  logic          result_timeout;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: running sum and sticky timeout per channel over a shot group
  int acc [CH];
  bit stk [CH];
  int nshot = 0;

  tdc_multi #(
    .CHANNELS       (CH),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TMO),
    .AVG_LOG2       (AVG)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sent_signal     (sent_signal),
    .recieved_signal (recieved_signal),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_chan     (result_chan),
    .result_delay    (result_delay),
    .result_timeout  (result_timeout),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      acc[i] = 0;
      stk[i] = 1'b0;
    end
    nshot = 0;
  endtask

  // Start pulse at cycle 0, stop pulses at d[i] and extra[i] (negative = none)
  task automatic drive_shot(input int d [CH], input int extra [CH]);
    int last = 0;
    for (int i = 0; i < CH; i++) begin
      if (d[i] > last) last = d[i];
      if (extra[i] > last) last = extra[i];
    end
    for (int c = 0; c <= last; c++) begin
      sent_signal = (c == 0);
      for (int i = 0; i < CH; i++) recieved_signal[i] = (d[i] == c) || (extra[i] == c);
      @(negedge clk);
    end
    sent_signal     = 1'b0;
    recieved_signal = '0;
  endtask

  task automatic collect(input int ed [CH], input bit et [CH], input int pct, input int stall);
    int got = 0;
    int budget = 400;
    int seen = 0;
    bit dropped = 1'b0;
    while (got < CH && budget > 0) begin
      @(negedge clk);
      budget--;
      if (result_valid) begin
        vectors++;
        if (result_chan !== 2'(got) || result_delay !== CW'(ed[got]) ||
            result_timeout !== et[got] || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL result: got chan=%0d delay=%0d tmo=%0b busy=%0b, want chan=%0d delay=%0d tmo=%0b busy=1",
                   result_chan, result_delay, result_timeout, busy, got, ed[got], et[got]);
        end
        seen++;
        if (stall > 0) sent_signal = (seen == 2);
        if (seen <= stall) result_ready = 1'b0;
        else result_ready = (int'($urandom_range(99)) < pct);
        if (result_ready) got++;
      end else begin
        result_ready = 1'b0;
        if (got > 0 && !dropped) begin
          dropped = 1'b1;
          vectors++;
          miscompares++;
          $display("FAIL valid_drop: valid low after %0d of %0d results, want high", got, CH);
        end
      end
    end
    if (got < CH) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout_wait: %0d of %0d results seen, want all", got, CH);
    end
    @(negedge clk);
    result_ready = 1'b0;
    sent_signal  = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_last: valid=%0b busy=%0b, want 0 0", result_valid, busy);
    end
  endtask

  task automatic wait_idle();
    int budget = 400;
    bit seen_busy = 1'b0;
    bit bad = 1'b0;
    while (budget > 0) begin
      @(negedge clk);
      budget--;
      if (result_valid) bad = 1'b1;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) break;
    end
    vectors++;
    if (bad || !seen_busy || budget == 0) begin
      miscompares++;
      $display("FAIL intermediate_shot: valid_seen=%0b busy_seen=%0b budget=%0d, want 0 1 >0",
               bad, seen_busy, budget);
    end
  endtask

  task automatic run_shot(input int d [CH], input int extra [CH], input int pct, input int stall);
    int ed [CH];
    bit et [CH];
    bit out;
    for (int i = 0; i < CH; i++) begin
      bit to;
      to = (d[i] < 0) || (d[i] > TMO);
      acc[i] += to ? TMO : d[i];
      stk[i] |= to;
    end
    nshot++;
    out = (nshot == SHOTS);
    if (out) begin
      for (int i = 0; i < CH; i++) begin
        ed[i] = acc[i] / SHOTS;
        et[i] = stk[i];
      end
      model_clear();
    end
    fork
      drive_shot(d, extra);
      if (out) collect(ed, et, pct, stall);
      else wait_idle();
    join
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sent_signal = 1'b0;
    recieved_signal = '0;
    result_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    vectors++;
    if (result_valid !== 1'b0 || result_chan !== 2'd0 || result_delay !== '0 ||
        result_timeout !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: valid=%0b chan=%0d delay=%0d tmo=%0b busy=%0b, want all 0",
               result_valid, result_chan, result_delay, result_timeout, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    repeat (SHOTS) run_shot('{10, 20, 30, 40}, '{-1, -1, -1, -1}, 100, 0);
  endtask

  task automatic test_timeout();
    repeat (SHOTS) run_shot('{5, 12, -1, 33}, '{-1, -1, -1, -1}, 100, 0);
  endtask

  task automatic test_boundary();
    repeat (SHOTS) run_shot('{50, 51, 0, 49}, '{-1, -1, -1, -1}, 100, 0);
  endtask

  task automatic test_same_cycle();
    repeat (SHOTS) run_shot('{7, 0, 15, 22}, '{-1, 5, -1, -1}, 100, 0);
  endtask

  task automatic test_stall();
    bit rearmed = 1'b0;
    repeat (SHOTS) run_shot('{4, 9, 14, 19}, '{-1, -1, -1, -1}, 100, 7);
    repeat (10) begin
      @(negedge clk);
      if (busy) rearmed = 1'b1;
    end
    vectors++;
    if (rearmed) begin
      miscompares++;
      $display("FAIL stall_start_ignored: busy=1 after output, want 0");
    end
  endtask

  task automatic test_reset_mid_count();
    bit bad = 1'b0;
    sent_signal = 1'b1;
    @(negedge clk);
    sent_signal = 1'b0;
    repeat (15) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_count_busy: busy=%0b, want 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    vectors++;
    if (result_valid !== 1'b0 || result_chan !== 2'd0 || result_delay !== '0 ||
        result_timeout !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%0b chan=%0d delay=%0d tmo=%0b busy=%0b, want all 0",
               result_valid, result_chan, result_delay, result_timeout, busy);
    end
    for (int c = 0; c < 60; c++) begin
      recieved_signal = (c % 10 == 3) ? 4'hF : 4'h0;
      @(negedge clk);
      if (result_valid || busy) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL abandoned_shot: activity after reset, want none");
    end
    repeat (SHOTS) run_shot('{3, 8, 13, 18}, '{-1, -1, -1, -1}, 100, 0);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2 * SHOTS; s++) begin
      run_shot('{s + 1, 2 * s + 2, 25 - s, 40 + s}, '{-1, -1, -1, -1}, 100, 0);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 4 * SHOTS; s++) begin
      int d [CH];
      int ex [CH];
      for (int i = 0; i < CH; i++) begin
        d[i]  = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(56));
        ex[i] = (d[i] >= 0 && $urandom_range(3) == 0) ? d[i] + 2 + int'($urandom_range(5)) : -1;
      end
      run_shot(d, ex, int'($urandom_range(100, 30)), 0);
    end
  endtask

`ifdef TDC_AVG_EN
  task automatic test_avg();
    run_shot('{10, 20, 20, 20}, '{-1, -1, -1, -1}, 100, 0);
    run_shot('{11, 20, 20, 20}, '{-1, -1, -1, -1}, 100, 0);
    run_shot('{12, 20, 20, 20}, '{-1, -1, -1, -1}, 100, 0);
    run_shot('{13, 20, 20, 20}, '{-1, -1, -1, -1}, 100, 0);
    run_shot('{10, 20, 20, 20}, '{-1, -1, -1, -1}, 100, 0);
    run_shot('{11, 20, 20, 20}, '{-1, -1, -1, -1}, 100, 0);
    run_shot('{12, 20, 20, 20}, '{-1, -1, -1, -1}, 100, 0);
    run_shot('{-1, 20, 20, 20}, '{-1, -1, -1, -1}, 100, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_boundary();
    test_same_cycle();
    test_stall();
    test_reset_mid_count();
    test_back_to_back();
    test_random();
`ifdef TDC_AVG_EN
    test_avg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
